// File: rtl/twos_comp_arbiter.sv
// Four-requester round-robin arbiter sharing one two's complement negation
// datapath; each transaction is grant -> compute -> hold result until accepted.
module twos_comp_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         gnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [1:0]         res_id,
  output logic               res_ovf,
  output logic [1:0]         state_dbg
);

  // Result handshake: a result transfers on a rising edge where res_valid and
  // res_ready are both high; res_valid/res_data/res_id/res_ovf hold until then,
  // and res_ready is ignored whenever res_valid is low.

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] OUT     = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       last_id;
  logic [1:0]       cur_id;
  logic [WIDTH-1:0] op;

  logic [1:0]       win_id;
  logic             win_found;
  logic [WIDTH-1:0] neg;
  logic             neg_ovf;

  // Round-robin search starts just after the last served requester and wraps.
  always_comb begin
    win_id    = last_id;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[2'(last_id + 2'(k))]) begin
        win_id    = 2'(last_id + 2'(k));
        win_found = 1'b1;
      end
    end
  end

  assign neg       = ~op + ONE;
  assign neg_ovf   = (op == MOST_NEG);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 2'd3;
      cur_id    <= 2'd0;
      op        <= '0;
      gnt       <= 4'b0000;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 2'd0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            op     <= req_data[win_id*WIDTH +: WIDTH];
            cur_id <= win_id;
            gnt    <= 4'b0001 << win_id;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          res_data  <= neg;
          res_id    <= cur_id;
          res_ovf   <= neg_ovf;
          res_valid <= 1'b1;
          gnt       <= 4'b0000;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            last_id   <= res_id;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= 4'b0000;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_comp_arbiter.sv
// Directed and randomized checks of twos_comp_arbiter against a transaction-level
// model: round-robin pick by search order, result = (2^W - op) mod 2^W.
module tb_twos_comp_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] req_data;
  logic [3:0]     gnt;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_ovf;
  logic [1:0]     state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int model_last = 3;
  int prev_gnt_cyc = -1;
  logic [W-1:0] exp_q[$];

  twos_comp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; req_data = '0; res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_last = 3;
    prev_gnt_cyc = -1;
  endtask

  // One full transaction; gap_chk compares spacing to the previous grant.
  task automatic do_txn(input logic [3:0] r, input logic [4*W-1:0] d,
                        input int delay, input bit early, input bit gap_chk);
    int exp_id;
    int exp_op;
    int exp_res;
    bit got;
    req = r; req_data = d; res_ready = early;
    exp_id = pick(r, model_last);
    exp_op = int'(d[exp_id*W +: W]);
    exp_res = ((1 << W) - exp_op) % (1 << W);
    exp_q.push_back(W'(exp_res));
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (gnt !== 4'b0000) got = 1'b1;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (!got) begin
      void'(exp_q.pop_front());
      return;
    end
    check("gnt_onehot", 32'(gnt), 32'(1 << exp_id));
    check("valid_low_in_compute", 32'(res_valid), 32'd0);
    if (gap_chk && prev_gnt_cyc >= 0) check("gnt_gap", 32'(cyc - prev_gnt_cyc), 32'd3);
    prev_gnt_cyc = cyc;
    // disturb inputs after the grant edge; the result must not move
    req = 4'($urandom); req_data = (4*W)'($urandom);
    step();
    check("gnt_pulse_end", 32'(gnt), 32'd0);
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
    check("res_id", 32'(res_id), 32'(exp_id));
    check("res_ovf", 32'(res_ovf), 32'(exp_op == (1 << (W-1))));
    if (!early) begin
      for (int i = 0; i < delay; i++) begin
        req = 4'($urandom | 1);
        step();
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data", 32'(res_data), 32'(exp_res));
        check("hold_id", 32'(res_id), 32'(exp_id));
        check("hold_no_gnt", 32'(gnt), 32'd0);
      end
    end
    res_ready = 1'b1;
    step();
    check("accept_valid_low", 32'(res_valid), 32'd0);
    check("accept_no_gnt", 32'(gnt), 32'd0);
    res_ready = 1'b0;
    req = 4'b0000;
    model_last = exp_id;
  endtask

  function automatic logic [4*W-1:0] lane(input int idx, input logic [W-1:0] v);
    logic [4*W-1:0] d;
    d = (4*W)'($urandom);
    d[idx*W +: W] = v;
    return d;
  endfunction

  initial begin
    // reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_ovf", 32'(res_ovf), 32'd0);

    // idle with no request stays quiet, res_ready ignored
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_gnt", 32'(gnt), 32'd0);
      check("idle_no_valid", 32'(res_valid), 32'd0);
    end
    res_ready = 1'b0;

    // single request, operand 0011 -> 1101
    do_txn(4'b0001, lane(0, 4'b0011), 1, 1'b0, 1'b0);

    // boundaries and every operand value on random single requesters
    do_txn(4'b0001, lane(0, 4'b0000), 0, 1'b0, 1'b0);
    do_txn(4'b0001, lane(0, 4'b1000), 0, 1'b0, 1'b0);
    do_txn(4'b0001, lane(0, 4'b0111), 0, 1'b0, 1'b0);
    for (int v = 0; v < 16; v++) begin
      int r;
      r = int'($urandom_range(0, 3));
      do_txn(4'(1 << r), lane(r, 4'(v)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    // fairness: all requesting, grant order 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int i = 0; i < 5; i++) do_txn(4'b1111, (4*W)'($urandom), 0, 1'b0, 1'b1);

    // backpressure then the next winner after requester 0
    do_reset();
    do_txn(4'b0001, lane(0, 4'b0101), 5, 1'b0, 1'b0);
    do_txn(4'b0110, (4*W)'($urandom), 0, 1'b0, 1'b0);

    // reset during COMPUTE discards the transaction
    req = 4'b0010; req_data = (4*W)'($urandom);
    step();
    check("pre_rst_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0;
    model_last = 3;
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    step();
    check("midrst_no_result", 32'(res_valid), 32'd0);
    do_txn(4'b1000, lane(3, 4'b0110), 0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      do_txn(4'($urandom_range(1, 15)), (4*W)'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twos_comp_arbiter.md
TWOS_COMP_ARBITER -- requirements
Module: twos_comp_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; all other parameters fixed (4 requesters).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  per-requester request; bit i = requester i.
REQ-005 Port: req_data  input  4*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 Port: gnt  output  4  one-hot grant pulse; bit i = requester i captured.
REQ-007 Port: res_valid  output  1  result available.
REQ-008 Port: res_ready  input  1  consumer accepts result.
REQ-009 Port: res_data  output  WIDTH  two's complement (negation) of granted operand.
REQ-010 Port: res_id  output  2  index of requester that owns res_data.
REQ-011 Port: res_ovf  output  1  operand was most-negative value (1 followed by zeros); negation unrepresentable.

Function
REQ-012 Block SHALL share one internal two's complement datapath (~x + 1, modulo 2^WIDTH) among 4 requesters.
REQ-013 FSM SHALL have exactly three states: IDLE, COMPUTE, OUT.
REQ-014 IDLE, req == 0: SHALL remain IDLE; gnt stays 0.
REQ-015 IDLE, req != 0: at edge SHALL select winner round-robin, searching from (last_id+1) mod 4 upward with wrap; SHALL latch winner's req_data and index, drive gnt one-hot for winner, go COMPUTE.
REQ-016 gnt SHALL be high exactly one cycle (the COMPUTE cycle); requester SHALL consider its request served when gnt bit seen.
REQ-017 Operand SHALL be sampled only at the grant edge; later changes to req/req_data SHALL not affect the result.
REQ-018 COMPUTE: at next edge SHALL register res_data = (~op + 1) truncated to WIDTH, res_id = winner, res_ovf = (op == 1000..0), res_valid = 1, gnt = 0, go OUT.
REQ-019 OUT: res_valid, res_data, res_id, res_ovf SHALL hold stable while res_ready == 0.
REQ-020 OUT, res_ready == 1: at edge SHALL clear res_valid, set last_id = res_id, go IDLE.
REQ-021 Latency: grant edge to res_valid high = 1 cycle; minimum 3 cycles per transaction; no request is accepted while COMPUTE or OUT.
REQ-022 Operand 0 SHALL yield res_data 0, res_ovf 0; most-negative operand SHALL yield itself, res_ovf 1.
REQ-023 A requester holding req continuously SHALL not be granted twice in a row while another requester is requesting.
REQ-024 res_ready while not in OUT SHALL be ignored.

Reset
REQ-025 rst high at edge SHALL force state IDLE, gnt 0, res_valid 0, res_data 0, res_id 0, res_ovf 0, last_id 3 (requester 0 has first priority).
REQ-026 rst SHALL override all other inputs in any state; an in-flight transaction is discarded without result.

Verification
REQ-027 Single request: WIDTH=4, req=0001, req_data[3:0]=0011 -> gnt=0001 one cycle, then res_valid=1, res_data=1101, res_id=0, res_ovf=0; all 16 operands 0000..1111 checked against ~x+1.
REQ-028 Boundary values: operand 0000 -> res_data 0000, ovf 0; operand 1000 -> res_data 1000, ovf 1; operand 0111 -> 1001.
REQ-029 Fairness: req=1111 held, res_ready=1 -> grant order 0,1,2,3,0 with gnt pulses every 3 cycles.
REQ-030 Backpressure: res_ready=0 for 5 cycles in OUT -> outputs stable, no new gnt despite req=0110; res_ready=1 -> next gnt=0010 (after last_id 0).
REQ-031 Reset mid-operation: rst asserted in COMPUTE -> next cycle res_valid=0, gnt=0, state IDLE; next request req=1000 granted first after requester-0 priority search (gnt=1000).
REQ-032 Operand stability: req_data changed the cycle after gnt -> res_data reflects value captured at grant edge.
